serial_add_scheduler: RTL
=========================

// Module: serial_add_scheduler
// PURPOSE
//  Shares one bit-serial adder among N_REQ requesters. Round-robin arbitrates
//  parallel operand requests and shifts the winner's operands LSB-first through
//  the serial adder, one bit pair per clk with vld/last framing. Collects the
//  sum bits and returns the W-bit sum plus carry-out, tagged with requester id.
// PARAMETERS
//  N_REQ  4  number of requesters (>=1)
//  W      8  operand width in bits (>=1)
// PORTS
//  clk        in   1         single clock; all logic on posedge
//  rst_n      in   1         synchronous reset, active-low
//  req_vld    in   N_REQ     requester i has operands on req_a/req_b slice i
//  req_a      in   N_REQ*W   operand A, slice i = [i*W +: W]
//  req_b      in   N_REQ*W   operand B, same slicing
//  req_rdy    out  N_REQ     one-hot grant; transfer when req_vld[i]&req_rdy[i]
//  res_vld    out  1         result valid, held until res_rdy
//  res_rdy    in   1         consumer accepts result
//  res_sum    out  W         A+B mod 2^W
//  res_cout   out  1         carry out of bit W-1
//  res_id     out  max(1,$clog2(N_REQ))  index of requester served
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=0, bit counter=0, carry=0,
//    res_vld=0, res_sum=0, res_cout=0, res_id=0; req_rdy=0 while rst_n=0.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: req_rdy = one-hot of first req_vld[i] searching from rr_ptr upward,
//    wrapping; combinational from req_vld, only nonzero in IDLE. On a transfer:
//    latch A, B, id; rr_ptr <= id+1 (wraps to 0 past N_REQ-1); cnt <= 0; ->SHIFT.
//    No req_vld: stay IDLE, nothing latched.
//  - SHIFT: each cycle drive adder vld=1, a=A[cnt], b=B[cnt], last=(cnt==W-1);
//    sum bit stored to sum_reg[cnt]; carry updates. At cnt==W-1 capture carry-out,
//    adder carry clears (last&vld), -> DONE. Exactly W SHIFT cycles; adder vld=0
//    in every other state, so carry is 0 at start of each operation.
//  - DONE: res_vld=1, res_sum/res_cout/res_id stable. res_rdy=1 -> IDLE next
//    cycle, res_vld drops. No grant issued in DONE or SHIFT.
//  - Latency: transfer at cycle T -> res_vld first high at T+W+1. Max throughput
//    one result per W+2 cycles (with res_rdy tied high).
//  - Arithmetic: {res_cout,res_sum} = A + B, full W+1 bits, unsigned.
//  - Boundaries: all req_vld high -> grants strictly rotate 0,1,..,N_REQ-1,0.
//    Single requester repeatedly -> served every W+2 cycles. N_REQ=1 -> res_id=0.
//    W=1 -> one SHIFT cycle, last asserted on it. req_vld dropped by a non-granted
//    requester has no effect. Reset mid-SHIFT or in DONE: operation discarded,
//    no res_vld, state/outputs to reset values, rr_ptr=0.
//    Operand inputs may change after transfer; latched copy is used.
// STRUCTURE
//  - Package serial_add_pkg: typedef enum logic [1:0] {IDLE,SHIFT,DONE} sched_state_t;
//    localparam default widths.
//  - Sub-module serial_adder_core: 1-bit full adder + carry flop, ports clk,rst_n,
//    vld,a,b,last,sum,carry_out; carry clears on rst_n=0, on vld&last, and when !vld.
//  - Top: RR arbiter (rotate/priority-encode), FSM, bit counter, operand and
//    sum registers.
// TESTING
//  1. Reset: hold rst_n=0 3 cycles with req_vld=4'hF -> req_rdy=0, res_vld=0, all outs 0.
//  2. Single: req 2 A=8'h5A B=8'h33 -> rdy[2] at T, res_vld at T+9, sum=8'h8D cout=0 id=2.
//  3. Carry: A=8'hFF B=8'h01 -> sum=8'h00 cout=1; next op A=1 B=1 -> sum=8'h02 (no stale carry).
//  4. RR: req_vld=4'hF held, res_rdy=1 -> res_id sequence 0,1,2,3,0, one result/10 cycles.
//  5. Backpressure: res_rdy=0 for 5 cycles after res_vld -> result stable, no new grant;
//     res_rdy=1 -> next grant one cycle after return to IDLE.
//  6. Mid-op reset: rst_n=0 at 4th SHIFT cycle -> no res_vld; new req after -> correct sum, id from ptr 0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and default widths for the serial-adder scheduler.
package serial_add_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned W_DEF     = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sched_state_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_core.sv
// One-bit full adder with a carry flop, fed one bit pair per clock LSB-first.
module serial_adder_core (
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  input  logic a,
  input  logic b,
  input  logic last,
  output logic sum,
  output logic carry_out
);

  logic carry;

  always_comb begin
    sum       = a ^ b ^ carry;
    carry_out = (a & b) | (carry & (a ^ b));
  end

  // Carry is only live between vld beats of one operation.
  always_ff @(posedge clk) begin
    if (!rst_n || !vld || last) carry <= 1'b0;
    else                        carry <= carry_out;
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one bit-serial adder among N_REQ requesters.
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req_vld,
  input  logic [N_REQ*W-1:0]              req_a,
  input  logic [N_REQ*W-1:0]              req_b,
  output logic [N_REQ-1:0]                req_rdy,
  output logic                            res_vld,
  input  logic                            res_rdy,
  output logic [W-1:0]                    res_sum,
  output logic                            res_cout,
  output logic [clog2_min1(N_REQ)-1:0]    res_id
);

  localparam int unsigned IW = clog2_min1(N_REQ);
  localparam int unsigned CW = clog2_min1(W);
  localparam logic [IW-1:0] ID_LAST  = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  sched_state_t  state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] id_reg;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] scan_id;
  logic          gnt_any;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  a_sel;
  logic [W-1:0]  b_sel;
  logic [W-1:0]  sum_reg;
  logic [W-1:0]  sum_next;
  logic          add_vld;
  logic          add_last;
  logic          add_sum;
  logic          add_cout;

  // Rotating priority search starting at rr_ptr; grants only in IDLE.
  always_comb begin
    req_rdy = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    scan_id = '0;
    a_sel   = '0;
    b_sel   = '0;
    if (rst_n && state == IDLE) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        scan_id = IW'((32'(rr_ptr) + i) % N_REQ);
        if (!gnt_any && req_vld[scan_id]) begin
          gnt_any          = 1'b1;
          gnt_id           = scan_id;
          req_rdy[scan_id] = 1'b1;
        end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_rdy[i]) begin
          a_sel = req_a[i*W +: W];
          b_sel = req_b[i*W +: W];
        end
      end
    end
  end

  always_comb begin
    add_vld  = (state == SHIFT);
    add_last = add_vld && (cnt == CNT_LAST);
  end

  // Merge the current sum bit so the final beat can land straight in res_sum.
  always_comb begin
    sum_next      = sum_reg;
    sum_next[cnt] = add_sum;
  end

  serial_adder_core u_adder (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (add_vld),
    .a         (a_reg[cnt]),
    .b         (b_reg[cnt]),
    .last      (add_last),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      id_reg   <= '0;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      res_vld  <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            a_reg  <= a_sel;
            b_reg  <= b_sel;
            id_reg <= gnt_id;
            rr_ptr <= (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sum_reg <= sum_next;
          if (cnt == CNT_LAST) begin
            res_sum  <= sum_next;
            res_cout <= add_cout;
            res_id   <= id_reg;
            res_vld  <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_rdy) begin
            res_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
